// File: rtl/frame_assembler_if.sv
// Symbol-in / frame-out bundle between the line decoder and the frame assembler.
// The master drives symbol strobes; the slave (assembler) drives the frame outputs.
interface frame_assembler_if #(
  parameter int unsigned DATA_W = 28
);
  logic              i_ena;
  logic              i_zero;
  logic              i_one;
  logic              i_head;
  logic [DATA_W-1:0] o_package;
  logic [1:0]        o_type;
  logic              o_ready;
  logic              o_parity_err;
  logic              o_sync_err;

  modport master (
    output i_ena, i_zero, i_one, i_head,
    input  o_package, o_type, o_ready, o_parity_err, o_sync_err
  );

  modport slave (
    input  i_ena, i_zero, i_one, i_head,
    output o_package, o_type, o_ready, o_parity_err, o_sync_err
  );
endinterface

// File: rtl/frame_assembler.sv
// Hunts X/Y/Z preambles in the decoded symbol stream, then assembles DATA_W payload
// bits into a tagged word with parity check and sync-error reporting.
module frame_assembler #(
  parameter int unsigned DATA_W    = 28,
  parameter bit          PARITY_EN = 1'b1,
  parameter bit          LSB_FIRST = 1'b1,
  parameter logic [7:0]  PRE_X     = 8'b01011111,
  parameter logic [7:0]  PRE_Y     = 8'b01001100,
  parameter logic [7:0]  PRE_Z     = 8'b01111101
) (
  input  logic i_clk,
  input  logic i_rst_n,
  frame_assembler_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    HUNT,
    DATA
  } state_e;

  state_e              state_q, state_d;
  // Only the three most recent symbols are needed to form the next 4-symbol window.
  logic [5:0]          pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [1:0]          type_q, type_d;
  logic [DATA_W-1:0]   pkg_q, pkg_d;
  logic [1:0]          otype_q, otype_d;
  logic                ready_q, ready_d;
  logic                perr_q, perr_d;
  logic                serr_q, serr_d;

  logic [1:0]          n_strb;
  logic                sym_valid;
  logic                sym_illegal;
  logic [1:0]          code;
  logic [7:0]          pre_nxt;
  logic [DATA_W-1:0]   word;

  always_comb begin
    n_strb      = {1'b0, bus.i_zero} + {1'b0, bus.i_one} + {1'b0, bus.i_head};
    sym_valid   = bus.i_ena && (n_strb == 2'd1);
    sym_illegal = bus.i_ena && (n_strb >= 2'd2);
    code        = bus.i_one ? 2'b11 : (bus.i_head ? 2'b01 : 2'b00);
    pre_nxt     = {pre_q, code};
    if (LSB_FIRST) begin
      word = {bus.i_one, shift_q[DATA_W-1:1]};
    end else begin
      word = {shift_q[DATA_W-2:0], bus.i_one};
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    type_d  = type_q;
    pkg_d   = pkg_q;
    otype_d = otype_q;
    perr_d  = perr_q;
    ready_d = 1'b0;
    serr_d  = 1'b0;

    if (sym_illegal) begin
      serr_d  = 1'b1;
      pre_d   = '0;
      cnt_d   = '0;
      state_d = HUNT;
    end else if (sym_valid) begin
      unique case (state_q)
        HUNT: begin
          pre_d = pre_nxt[5:0];
          if (pre_nxt == PRE_X || pre_nxt == PRE_Y || pre_nxt == PRE_Z) begin
            type_d  = (pre_nxt == PRE_X) ? 2'b01 :
                      (pre_nxt == PRE_Y) ? 2'b10 : 2'b11;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (bus.i_head) begin
            // The aborting head symbol becomes the first symbol of the next hunt.
            serr_d  = 1'b1;
            pre_d   = 6'b000001;
            cnt_d   = '0;
            state_d = HUNT;
          end else begin
            shift_d = word;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              pkg_d   = word;
              otype_d = type_q;
              perr_d  = PARITY_EN ? ^word : 1'b0;
              ready_d = 1'b1;
              pre_d   = '0;
              cnt_d   = '0;
              state_d = HUNT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HUNT;
      pre_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      type_q  <= '0;
      pkg_q   <= '0;
      otype_q <= '0;
      perr_q  <= 1'b0;
      ready_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      type_q  <= type_d;
      pkg_q   <= pkg_d;
      otype_q <= otype_d;
      perr_q  <= perr_d;
      ready_q <= ready_d;
      serr_q  <= serr_d;
    end
  end

  assign bus.o_package    = pkg_q;
  assign bus.o_type       = otype_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_sync_err   = serr_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler: a frame table plus hand sequences for aborts,
// illegal symbols, gapped enables and reset mid-frame, across three parameter builds.
module tb_frame_assembler;

  localparam logic [7:0] PX = 8'b01011111;
  localparam logic [7:0] PY = 8'b01001100;
  localparam logic [7:0] PZ = 8'b01111101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0, zero = 1'b0, one = 1'b0, head = 1'b0;
  logic gap_mode = 1'b0;

  always #5 clk = ~clk;

  frame_assembler_if #(.DATA_W(28)) if_a ();
  frame_assembler_if #(.DATA_W(28)) if_np ();
  frame_assembler_if #(.DATA_W(28)) if_msb ();

  assign if_a.i_ena = ena;    assign if_a.i_zero = zero;
  assign if_a.i_one = one;    assign if_a.i_head = head;
  assign if_np.i_ena = ena;   assign if_np.i_zero = zero;
  assign if_np.i_one = one;   assign if_np.i_head = head;
  assign if_msb.i_ena = ena;  assign if_msb.i_zero = zero;
  assign if_msb.i_one = one;  assign if_msb.i_head = head;

  frame_assembler #(.DATA_W(28)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
  frame_assembler #(.DATA_W(28), .PARITY_EN(1'b0)) dut_np (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_np.slave));
  frame_assembler #(.DATA_W(28), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_msb.slave));

  typedef struct packed {
    logic [27:0] pkg;
    logic [1:0]  typ;
    logic        perr;
    logic        perr_np;
    logic [27:0] pkg_msb;
  } cap_t;

  typedef struct {
    logic [7:0]  pre;
    logic [27:0] data;
    logic [1:0]  typ;
    logic        perr;
  } vec_t;

  cap_t caps[$];
  int   tests = 0;
  int   errors = 0;
  int   serr_cnt = 0;
  int   both_cnt = 0;
  int   long_ready = 0;
  int   long_serr = 0;
  logic prev_ready = 1'b0;
  logic prev_serr = 1'b0;

  always @(negedge clk) begin
    if (if_a.o_ready)
      caps.push_back('{if_a.o_package, if_a.o_type, if_a.o_parity_err,
                       if_np.o_parity_err, if_msb.o_package});
    if (if_a.o_sync_err) serr_cnt++;
    if (if_a.o_ready && if_a.o_sync_err) both_cnt++;
    if (if_a.o_ready && prev_ready) long_ready++;
    if (if_a.o_sync_err && prev_serr) long_serr++;
    prev_ready = if_a.o_ready;
    prev_serr  = if_a.o_sync_err;
  end

  function automatic logic [27:0] rev28(input logic [27:0] v);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = v[27-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sym(input logic [1:0] c);
    ena = 1'b1; zero = (c == 2'b00); one = (c == 2'b11); head = (c == 2'b01);
    @(posedge clk); #1;
    ena = 1'b0; zero = 1'b0; one = 1'b0; head = 1'b0;
    if (gap_mode) begin
      // ena low with every strobe up must be ignored, then an ena-only idle cycle
      zero = 1'b1; one = 1'b1; head = 1'b1;
      @(posedge clk); #1;
      zero = 1'b0; one = 1'b0; head = 1'b0; ena = 1'b1;
      @(posedge clk); #1;
      ena = 1'b0;
    end
  endtask

  task automatic send_pre(input logic [7:0] p);
    for (int i = 0; i < 4; i++) sym(p[7-2*i -: 2]);
  endtask

  task automatic send_bits(input logic [27:0] d, input int n);
    for (int i = 0; i < n; i++) sym(d[i] ? 2'b11 : 2'b00);
  endtask

  task automatic illegal_sym();
    ena = 1'b1; zero = 1'b1; one = 1'b1; head = 1'b0;
    @(posedge clk); #1;
    ena = 1'b0; zero = 1'b0; one = 1'b0;
  endtask

  task automatic wait_caps(input string name, input int n);
    for (int c = 0; c < 20 && caps.size() < n; c++) begin
      @(negedge clk); #1;
    end
    chk({name, " ready count"}, 32'(caps.size()), 32'(n));
  endtask

  task automatic check_frame(input string name, input logic [27:0] d,
                             input logic [1:0] t, input logic pe);
    cap_t c;
    if (caps.size() == 0) begin
      tests++; errors++;
      $display("FAIL %s: no frame captured, expected %h", name, d);
    end else begin
      c = caps.pop_front();
      chk({name, " package"}, 32'(c.pkg), 32'(d));
      chk({name, " type"}, 32'(c.typ), 32'(t));
      chk({name, " parity"}, 32'(c.perr), 32'(pe));
      chk({name, " parity_np"}, 32'(c.perr_np), 32'(0));
      chk({name, " package_msb"}, 32'(c.pkg_msb), 32'(rev28(d)));
    end
  endtask

  vec_t vecs[5];
  int   s0;

  initial begin
    vecs[0] = '{PX, 28'h0A55A5A, 2'b01, 1'b0};
    vecs[1] = '{PZ, 28'h0000001, 2'b11, 1'b1};
    vecs[2] = '{PY, 28'hFFFFFFF, 2'b10, 1'b0};
    vecs[3] = '{PX, 28'h8000000, 2'b01, 1'b1};
    vecs[4] = '{PZ, 28'h0000000, 2'b11, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset package", 32'(if_a.o_package), 32'(0));
    chk("reset type", 32'(if_a.o_type), 32'(0));
    chk("reset ready", 32'(if_a.o_ready), 32'(0));
    chk("reset parity", 32'(if_a.o_parity_err), 32'(0));
    chk("reset sync", 32'(if_a.o_sync_err), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      send_pre(vecs[v].pre);
      send_bits(vecs[v].data, 28);
      wait_caps($sformatf("vec%0d", v), 1);
      check_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].typ, vecs[v].perr);
    end
    chk("table no sync_err", 32'(serr_cnt), 32'(0));

    // back-to-back frames, second preamble starts right after the last data bit
    send_pre(PX); send_bits(28'h0A55A5A, 28);
    send_pre(PZ); send_bits(28'h0000001, 28);
    wait_caps("b2b", 2);
    check_frame("b2b first", 28'h0A55A5A, 2'b01, 1'b0);
    check_frame("b2b second", 28'h0000001, 2'b11, 1'b1);

    // head inside Y data aborts and seeds the next hunt
    s0 = serr_cnt;
    send_pre(PY); send_bits(28'h3FF, 10); sym(2'b01);
    @(negedge clk); #1;
    chk("abort sync_err", 32'(serr_cnt - s0), 32'(1));
    chk("abort no ready", 32'(caps.size()), 32'(0));
    chk("abort pkg held", 32'(if_a.o_package), 32'(28'h0000001));
    sym(2'b00); sym(2'b11); sym(2'b00);
    send_bits(28'h1234567, 28);
    wait_caps("seeded Y", 1);
    check_frame("seeded Y", 28'h1234567, 2'b10, 1'b0);

    // illegal symbol in HUNT and in DATA
    s0 = serr_cnt;
    illegal_sym();
    @(negedge clk); #1;
    chk("illegal hunt sync_err", 32'(serr_cnt - s0), 32'(1));
    send_pre(PX); send_bits(28'h1F, 5); illegal_sym();
    @(negedge clk); #1;
    chk("illegal data sync_err", 32'(serr_cnt - s0), 32'(2));
    chk("illegal no ready", 32'(caps.size()), 32'(0));
    chk("illegal pkg held", 32'(if_a.o_package), 32'(28'h1234567));
    send_pre(PX); send_bits(28'h0A55A5A, 28);
    wait_caps("after illegal", 1);
    check_frame("after illegal", 28'h0A55A5A, 2'b01, 1'b0);

    // gapped enables and ignored strobes
    s0 = serr_cnt;
    gap_mode = 1'b1;
    send_pre(PX); send_bits(28'h0A55A5A, 28);
    gap_mode = 1'b0;
    wait_caps("gapped", 1);
    check_frame("gapped", 28'h0A55A5A, 2'b01, 1'b0);
    chk("gapped no sync_err", 32'(serr_cnt - s0), 32'(0));

    // reset mid-frame at bit 15
    s0 = serr_cnt;
    send_pre(PZ); send_bits(28'h7FFF, 15);
    rst_n = 1'b0;
    #1;
    chk("midrst package", 32'(if_a.o_package), 32'(0));
    chk("midrst type", 32'(if_a.o_type), 32'(0));
    chk("midrst parity", 32'(if_a.o_parity_err), 32'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst no ready", 32'(caps.size()), 32'(0));
    chk("midrst no sync_err", 32'(serr_cnt - s0), 32'(0));
    send_pre(PX); send_bits(28'h0A55A5A, 28);
    wait_caps("post reset", 1);
    check_frame("post reset", 28'h0A55A5A, 2'b01, 1'b0);

    repeat (3) @(negedge clk);
    chk("ready with sync_err", 32'(both_cnt), 32'(0));
    chk("ready longer than 1", 32'(long_ready), 32'(0));
    chk("sync_err longer than 1", 32'(long_serr), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
